// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared constants and types for the cache-controller hit/miss dispatcher.
//   LINE_W / OFS_W / HIT_DATA_W : cache line width, byte-offset width and
//                                 the width of one hit-data FIFO entry
//   AXI_*                       : fixed AR attributes for a line refill
//                                 (8 beats of 8 bytes, wrapping burst)
//   cc_disp_state_e             : AR issue FSM states
// ---------------------------------------------------------------------------
package cc_pkg;

   localparam int LINE_W     = 512;
   localparam int OFS_W      = 6;
   localparam int HIT_DATA_W = OFS_W + LINE_W;

   localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [3:0] AXI_LEN_LINE   = 4'd7;

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_AR_WAIT = 1'b1
   } cc_disp_state_e;

endpackage

// File: rtl/cc_hit_miss_dispatcher_if.sv
// ---------------------------------------------------------------------------
// cc_hit_miss_dispatcher_if
// Bundles every non-clock/reset signal of the dispatcher: the lookup request
// handshake, the two FIFO write ports, the memory AR channel and the snooped
// R-channel handshake. Signal suffixes are from the dispatcher's viewpoint.
//   modport slave  : the dispatcher itself
//   modport master : the surrounding logic (tag stage, FIFOs, memory)
// Parameter ADDR_WIDTH : request / AR address width.
// ---------------------------------------------------------------------------
interface cc_hit_miss_dispatcher_if #(
   parameter int ADDR_WIDTH = 32
);
   import cc_pkg::*;

   logic                   req_valid_i;
   logic                   req_ready_o;
   logic                   req_hit_i;
   logic [ADDR_WIDTH-1:0]  req_addr_i;
   logic [LINE_W-1:0]      req_line_i;

   logic                   hit_flag_fifo_afull_i;
   logic                   hit_flag_fifo_wren_o;
   logic                   hit_flag_fifo_wdata_o;

   logic                   hit_data_fifo_afull_i;
   logic                   hit_data_fifo_wren_o;
   logic [HIT_DATA_W-1:0]  hit_data_fifo_wdata_o;

   logic [ADDR_WIDTH-1:0]  mem_araddr_o;
   logic [3:0]             mem_arlen_o;
   logic [2:0]             mem_arsize_o;
   logic [1:0]             mem_arburst_o;
   logic                   mem_arvalid_o;
   logic                   mem_arready_i;

   logic                   mem_rvalid_i;
   logic                   mem_rready_i;
   logic                   mem_rlast_i;

   modport slave (
      input  req_valid_i, req_hit_i, req_addr_i, req_line_i,
      input  hit_flag_fifo_afull_i, hit_data_fifo_afull_i,
      input  mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
      output req_ready_o,
      output hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
      output hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
      output mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
      output mem_arvalid_o
   );

   modport master (
      output req_valid_i, req_hit_i, req_addr_i, req_line_i,
      output hit_flag_fifo_afull_i, hit_data_fifo_afull_i,
      output mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
      input  req_ready_o,
      input  hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o,
      input  hit_data_fifo_wren_o, hit_data_fifo_wdata_o,
      input  mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
      input  mem_arvalid_o
   );

endinterface

// File: rtl/cc_sat_counter.sv
// ---------------------------------------------------------------------------
// cc_sat_counter
// Up/down counter that saturates at both ends. Simultaneous inc and dec
// cancel out. A decrement at zero is treated as a protocol error by the
// caller; the count stays at zero and simulation flags it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears the count)
//   inc_i      : count up by one
//   dec_i      : count down by one
//   cnt_o      : current (registered) count
// Parameter WIDTH : counter width.
// ---------------------------------------------------------------------------
module cc_sat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: move one step in the requested direction unless the count
   // is already pinned at that end of its range.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   // Underflow means the environment retired something that was never
   // counted in.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(dec_i && !inc_i && (cnt_q == '0)))
            else $error("cc_sat_counter: decrement at zero");
      end
   end
`endif

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cc_hit_miss_dispatcher.sv
// ---------------------------------------------------------------------------
// cc_hit_miss_dispatcher
// Write side of the cache-controller read-data reorder path. Accepts one
// tag-compare result per cycle. Every accepted request pushes its hit flag
// into the hit-flag FIFO; hits also push {offset, line} into the hit-data
// FIFO, misses issue an 8-beat 64-bit WRAP AR burst starting at the
// critical doubleword. The number of misses whose R burst has not finished
// is bounded by snooping R-channel last beats.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : cc_hit_miss_dispatcher_if.slave (request, FIFO writes,
//                AR channel, snooped R handshake)
//   hit_cnt_o, miss_cnt_o : accepted hit / miss statistics, present only
//                when CC_DISPATCH_STATS_EN is defined
// Parameters:
//   ADDR_WIDTH      : request / AR address width (match the interface)
//   MAX_OUTSTANDING : max misses in flight, 1..15
// Build option: CC_DISPATCH_STATS_EN adds the two saturating counters.
// ---------------------------------------------------------------------------
module cc_hit_miss_dispatcher
   import cc_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   cc_hit_miss_dispatcher_if.slave bus
`ifdef CC_DISPATCH_STATS_EN
   ,
   output logic [31:0]             hit_cnt_o,
   output logic [31:0]             miss_cnt_o
`endif
);

   localparam logic [0:0] ST_IDLE    = S_IDLE;
   localparam logic [0:0] ST_AR_WAIT = S_AR_WAIT;
   localparam logic [3:0] MAX_CNT    = 4'(MAX_OUTSTANDING);

   logic [0:0]            state_q;
   logic [0:0]            state_d;
   logic [ADDR_WIDTH-1:0] arAddr_q;
   logic [ADDR_WIDTH-1:0] arAddr_d;
   logic [3:0]            outCnt;
   logic                  arSlotFree;
   logic                  belowMax;
   logic                  accept;
   logic                  hitAccept;
   logic                  missAccept;
   logic                  rLastSeen;

   // A new miss can only be accepted if the AR register is free or is being
   // handed off this cycle. The same qualifier gates hits so that the flag
   // and data FIFOs never get ahead of a stalled miss.
   assign arSlotFree = (state_q == ST_IDLE) | bus.mem_arready_i;
   assign belowMax   = (outCnt < MAX_CNT);

   assign bus.req_ready_o = ~bus.hit_flag_fifo_afull_i & ~bus.hit_data_fifo_afull_i
                            & arSlotFree & belowMax;

   assign accept     = bus.req_valid_i & bus.req_ready_o;
   assign hitAccept  = accept & bus.req_hit_i;
   assign missAccept = accept & ~bus.req_hit_i;
   assign rLastSeen  = bus.mem_rvalid_i & bus.mem_rready_i & bus.mem_rlast_i;

   // FIFO writes happen in the accept cycle itself.
   assign bus.hit_flag_fifo_wren_o  = accept;
   assign bus.hit_flag_fifo_wdata_o = bus.req_hit_i;
   assign bus.hit_data_fifo_wren_o  = hitAccept;
   assign bus.hit_data_fifo_wdata_o = {bus.req_addr_i[OFS_W-1:0], bus.req_line_i};

   // AR issue FSM. An accepted miss loads the doubleword-aligned address so
   // the wrap burst returns the critical word first. While waiting, the
   // address holds until the slave takes it; a miss arriving in the very
   // cycle of that handoff reloads the register and stays in AR_WAIT.
   always_comb begin
      state_d  = state_q;
      arAddr_d = arAddr_q;
      if (state_q == ST_IDLE) begin
         if (missAccept) begin
            state_d  = ST_AR_WAIT;
            arAddr_d = {bus.req_addr_i[ADDR_WIDTH-1:3], 3'b000};
         end
      end else begin
         if (bus.mem_arready_i) begin
            if (missAccept) begin
               arAddr_d = {bus.req_addr_i[ADDR_WIDTH-1:3], 3'b000};
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   // FSM and AR address registers. Reset drops any pending AR.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         arAddr_q <= '0;
      end else begin
         state_q  <= state_d;
         arAddr_q <= arAddr_d;
      end
   end

   assign bus.mem_arvalid_o = (state_q == ST_AR_WAIT);
   assign bus.mem_araddr_o  = arAddr_q;
   assign bus.mem_arlen_o   = AXI_LEN_LINE;
   assign bus.mem_arsize_o  = AXI_SIZE_8B;
   assign bus.mem_arburst_o = AXI_BURST_WRAP;

   // Misses in flight: counted in at acceptance, out at the R last beat.
   cc_sat_counter #(
      .WIDTH (4)
   ) u_out_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (missAccept),
      .dec_i (rLastSeen),
      .cnt_o (outCnt)
   );

`ifdef CC_DISPATCH_STATS_EN
   cc_sat_counter #(
      .WIDTH (32)
   ) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (hitAccept),
      .dec_i (1'b0),
      .cnt_o (hit_cnt_o)
   );

   cc_sat_counter #(
      .WIDTH (32)
   ) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (missAccept),
      .dec_i (1'b0),
      .cnt_o (miss_cnt_o)
   );
`endif

endmodule
